// File: rtl/dev_uart.sv
// dev_uart: memory-mapped UART responder on the uncached device port.
// Four registers, TX FIFO feeding an 8-N-1 transmitter, 1-byte 8-N-1 receiver.
module dev_uart #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CLKS_PER_BIT  = 868,
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    S_DEVICE_strobe_i,
  input  logic [ADDR_WIDTH-1:0]   S_DEVICE_addr_i,
  input  logic                    S_DEVICE_rw_i,
  input  logic [DATA_WIDTH/8-1:0] S_DEVICE_byte_enable_i,
  input  logic [DATA_WIDTH-1:0]   S_DEVICE_data_i,
  output logic                    S_DEVICE_data_ready_o,
  output logic [DATA_WIDTH-1:0]   S_DEVICE_data_o,
  output logic                    uart_tx_o,
  input  logic                    uart_rx_i
);
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } st_e;

  logic [1:0] reg_sel;
  logic rd_en, wr_en, rd_rx, push, clr_ovr, clr_fe;
  logic full, empty, tx_pop, tx_end, rx_end, rx_half, rx_s;
  logic [5:0] status;
  logic [DATA_WIDTH-1:0] rdata_d;

  logic rdy_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [7:0] mem_q [TX_FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;

  st_e tx_st_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_sh_q;
  logic tx_q;

  logic [1:0] sync_q;
  logic rx_prev_q;
  st_e rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_sh_q, rx_byte_q;
  logic rx_valid_q, rx_ovr_q, rx_fe_q;

  logic unused_bits;
  assign unused_bits = ^{S_DEVICE_addr_i[ADDR_WIDTH-1:4], S_DEVICE_addr_i[1:0],
                         S_DEVICE_data_i[DATA_WIDTH-1:8],
                         S_DEVICE_byte_enable_i[DATA_WIDTH/8-1:1]};

  assign reg_sel = S_DEVICE_addr_i[3:2];
  assign wr_en   = S_DEVICE_strobe_i & S_DEVICE_rw_i;
  assign rd_en   = S_DEVICE_strobe_i & ~S_DEVICE_rw_i;
  assign rd_rx   = rd_en && reg_sel == 2'd0;
  assign push    = wr_en && reg_sel == 2'd1 && S_DEVICE_byte_enable_i[0] && !full;
  assign clr_ovr = wr_en && reg_sel == 2'd3 && S_DEVICE_byte_enable_i[0] && S_DEVICE_data_i[1];
  assign clr_fe  = wr_en && reg_sel == 2'd3 && S_DEVICE_byte_enable_i[0] && S_DEVICE_data_i[5];

  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign tx_end = (tx_cnt_q == BIT_END);
  assign tx_pop = !empty && (tx_st_q == S_IDLE || (tx_st_q == S_STOP && tx_end));

  assign rx_s    = sync_q[1];
  assign rx_end  = (rx_cnt_q == BIT_END);
  assign rx_half = (rx_cnt_q == HALF_END);

  assign status = {rx_fe_q, tx_st_q != S_IDLE, empty, full, rx_ovr_q, rx_valid_q};

  assign S_DEVICE_data_ready_o = rdy_q;
  assign S_DEVICE_data_o       = rdata_q;
  assign uart_tx_o             = tx_q;

  // read mux; writes and write-only registers return zero
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (reg_sel)
        2'd0:    rdata_d[7:0] = rx_byte_q;
        2'd2:    rdata_d[5:0] = status;
        default: rdata_d = '0;
      endcase
    end
  end

  // one registered completion per strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdy_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdy_q   <= S_DEVICE_strobe_i;
      rdata_q <= rdata_d;
    end
  end

  // FIFO storage, no reset needed since pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= S_DEVICE_data_i[7:0];
  end

  // FIFO pointers, extra MSB distinguishes full from empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push)   wptr_q <= wptr_q + 1'b1;
      if (tx_pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  // transmitter: start, 8 data LSB first, stop; chains frames with no gap
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (tx_st_q)
        S_IDLE: begin
          tx_cnt_q <= '0;
          if (tx_pop) begin
            tx_sh_q <= mem_q[rptr_q[AW-1:0]];
            tx_q    <= 1'b0;
            tx_st_q <= S_START;
          end
        end
        S_START: begin
          if (tx_end) begin
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_q     <= tx_sh_q[0];
            tx_st_q  <= S_DATA;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        S_DATA: begin
          if (tx_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              tx_st_q <= S_STOP;
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              tx_sh_q  <= tx_sh_q >> 1;
              tx_q     <= tx_sh_q[1];
            end
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        default: begin
          if (tx_end) begin
            tx_cnt_q <= '0;
            if (tx_pop) begin
              tx_sh_q <= mem_q[rptr_q[AW-1:0]];
              tx_q    <= 1'b0;
              tx_st_q <= S_START;
            end else tx_st_q <= S_IDLE;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
      endcase
    end
  end

  // input synchronizer plus previous-sample flop for edge detect
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], uart_rx_i};
      rx_prev_q <= sync_q[1];
    end
  end

  // receiver and status flags; a completing frame overrides a same-cycle read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_st_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_fe_q    <= 1'b0;
    end else begin
      if (rd_rx)   rx_valid_q <= 1'b0;
      if (clr_ovr) rx_ovr_q   <= 1'b0;
      if (clr_fe)  rx_fe_q    <= 1'b0;
      case (rx_st_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_s) rx_st_q <= S_START;
        end
        S_START: begin
          if (rx_half) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rx_s ? S_IDLE : S_DATA;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        S_DATA: begin
          if (rx_end) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
            else rx_bit_q <= rx_bit_q + 1'b1;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        default: begin
          if (rx_end) begin
            rx_cnt_q <= '0;
            rx_st_q  <= S_IDLE;
            if (rx_s) begin
              rx_byte_q  <= rx_sh_q;
              rx_valid_q <= 1'b1;
              if (rx_valid_q && !rd_rx) rx_ovr_q <= 1'b1;
            end else rx_fe_q <= 1'b1;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dev_uart.sv
// tb_dev_uart: directed bench for dev_uart with CLKS_PER_BIT = 8, depth 8.
// Register vectors from a table, serial corner cases as short sequences.
module tb_dev_uart;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst, strobe, rw, rx, rdy, tx;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] be;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dev_uart #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .S_DEVICE_strobe_i(strobe), .S_DEVICE_addr_i(addr),
    .S_DEVICE_rw_i(rw), .S_DEVICE_byte_enable_i(be),
    .S_DEVICE_data_i(wdata), .S_DEVICE_data_ready_o(rdy),
    .S_DEVICE_data_o(rdata), .uart_tx_o(tx), .uart_rx_i(rx)
  );

  typedef struct {
    logic        w;
    logic [1:0]  r;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [1:0] r, input logic [3:0] b,
                     input logic [31:0] d, output logic [31:0] q, output logic ok);
    @(negedge clk);
    strobe = 1'b1; rw = w; addr = {28'h0, r, 2'b00}; be = b; wdata = d;
    @(negedge clk);
    strobe = 1'b0; rw = 1'b0; be = 4'h0; wdata = 32'h0;
    ok = rdy; q = rdata;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] q; logic ok;
    bus(1'b0, r, 4'h0, 32'h0, q, ok);
    chk({name, "_rdy"}, {31'h0, ok}, 32'h1);
    chk(name, q, exp);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] q; logic ok;
    bus(1'b1, r, 4'h1, d, q, ok);
    if (ok !== 1'b1 || q !== 32'h0) chk("wr_resp", {q[30:0], ok}, 32'h1);
  endtask

  task automatic cap(output logic [7:0] b, output logic ok);
    int n;
    ok = 1'b0; b = 8'h0; n = 0;
    while (tx !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    if (tx !== 1'b0) return;
    repeat (3) @(negedge clk);
    if (tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    ok = (tx === 1'b1);
  endtask

  task automatic send(input logic [7:0] v, input logic stop);
    logic [9:0] f;
    f = {stop, v, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); rx = f[k];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk); rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  vec_t tbl[9];
  logic [7:0] got[$];
  logic [7:0] fexp[9];

  initial begin
    logic [31:0] q; logic ok; logic [7:0] s; logic [9:0] frame;
    rst = 1'b1; strobe = 1'b0; rw = 1'b0; addr = 32'h0; be = 4'h0;
    wdata = 32'h0; rx = 1'b1;

    tbl[0] = '{1'b0, 2'd2, 4'h0, 32'h0,  32'h08};
    tbl[1] = '{1'b0, 2'd0, 4'h0, 32'h0,  32'h00};
    tbl[2] = '{1'b0, 2'd1, 4'h0, 32'h0,  32'h00};
    tbl[3] = '{1'b0, 2'd3, 4'h0, 32'h0,  32'h00};
    tbl[4] = '{1'b1, 2'd0, 4'hF, 32'hFF, 32'h00};
    tbl[5] = '{1'b1, 2'd1, 4'h0, 32'h41, 32'h00};
    tbl[6] = '{1'b1, 2'd3, 4'hF, 32'h22, 32'h00};
    tbl[7] = '{1'b0, 2'd2, 4'h0, 32'h0,  32'h08};
    tbl[8] = '{1'b0, 2'd0, 4'h0, 32'h0,  32'h00};

    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_rdy", {31'h0, rdy}, 32'h0);
    chk("rst_data", rdata, 32'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      bus(tbl[i].w, tbl[i].r, tbl[i].b, tbl[i].d, q, ok);
      chk($sformatf("vec%0d_rdy", i), {31'h0, ok}, 32'h1);
      chk($sformatf("vec%0d_data", i), q, tbl[i].exp);
    end

    // single frame 0x55 with cycle-exact start and bit widths
    @(negedge clk);
    strobe = 1'b1; rw = 1'b1; addr = 32'h4; be = 4'h1; wdata = 32'h55;
    @(negedge clk);
    strobe = 1'b0; rw = 1'b0; be = 4'h0; wdata = 32'h0;
    chk("tx_rdy_n1", {31'h0, rdy}, 32'h1);
    chk("tx_line_n1", {31'h0, tx}, 32'h1);
    @(negedge clk);
    chk("tx_rdy_n2", {31'h0, rdy}, 32'h0);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < CPB; c++) begin
        s[c] = tx;
        @(negedge clk);
      end
      chk($sformatf("tx_bit%0d", k), {24'h0, s}, {24'h0, {8{frame[k]}}});
    end
    chk("tx_after", {31'h0, tx}, 32'h1);
    rd_chk("tx_status_idle", 2'd2, 32'h08);

    // FIFO full: one byte in flight, then nine back-to-back pushes
    fexp[0] = 8'hF0;
    for (int i = 1; i < 9; i++) fexp[i] = 8'(i);
    fork
      begin : capture
        logic [7:0] b; logic cok;
        for (int i = 0; i < 10; i++) begin
          cap(b, cok);
          if (!cok) break;
          got.push_back(b);
        end
      end
      begin : writer
        int nr;
        nr = 0;
        wr(2'd1, 32'hF0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          @(negedge clk);
          if (i > 0 && rdy === 1'b1) nr++;
          strobe = 1'b1; rw = 1'b1; addr = 32'h4; be = 4'h1; wdata = 32'(i + 1);
        end
        @(negedge clk);
        if (rdy === 1'b1) nr++;
        strobe = 1'b0; rw = 1'b0; be = 4'h0; wdata = 32'h0;
        @(negedge clk);
        if (rdy === 1'b1) nr++;
        chk("fifo_rdy_count", nr, 32'd9);
        rd_chk("fifo_status_full", 2'd2, 32'h14);
      end
    join
    chk("fifo_frames", got.size(), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < got.size()) chk($sformatf("fifo_byte%0d", i), {24'h0, got[i]}, {24'h0, fexp[i]});
    rd_chk("fifo_status_drained", 2'd2, 32'h08);

    // receive one byte
    send(8'hA3, 1'b1);
    rd_chk("rx_status", 2'd2, 32'h09);
    rd_chk("rx_data", 2'd0, 32'hA3);
    rd_chk("rx_status_clr", 2'd2, 32'h08);

    // overrun
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    rd_chk("ovr_status", 2'd2, 32'h0B);
    rd_chk("ovr_data", 2'd0, 32'h22);
    rd_chk("ovr_status_rd", 2'd2, 32'h0A);
    wr(2'd3, 32'h02);
    rd_chk("ovr_status_clr", 2'd2, 32'h08);

    // framing error
    send(8'h5A, 1'b0);
    rd_chk("fe_status", 2'd2, 32'h28);
    rd_chk("fe_data_kept", 2'd0, 32'h22);
    wr(2'd3, 32'h20);
    rd_chk("fe_status_clr", 2'd2, 32'h08);

    // short start glitch
    @(negedge clk); rx = 1'b0;
    repeat (2) @(negedge clk); rx = 1'b1;
    repeat (40) @(negedge clk);
    rd_chk("glitch_status", 2'd2, 32'h08);

    // reset in the middle of a frame with a byte still queued
    wr(2'd1, 32'h00);
    wr(2'd1, 32'h00);
    repeat (20) @(negedge clk);
    chk("midframe_low", {31'h0, tx}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_line_high", {31'h0, tx}, 32'h1);
    repeat (2) @(negedge clk);
    chk("rst_rdy_low", {31'h0, rdy}, 32'h0);
    rst = 1'b0;
    rd_chk("rst_status", 2'd2, 32'h08);
    cap(s, ok);
    chk("rst_no_frame", {31'h0, ok}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dev_uart.md
# dev_uart

Memory-mapped UART responder on the Aquila uncached device port (0xC000_0000 segment). It answers the core's single-word strobe/ready device requests and provides a 4-register programming model. Behind the registers it has an 8-N-1 transmitter fed by a small TX FIFO and an 8-N-1 receiver holding a single byte. It sits outside the core, between the `M_DEVICE_*` master port and the board UART pins.

## Interface
- `ADDR_WIDTH`, 32: device bus address width.
- `DATA_WIDTH`, 32: device bus data width.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- `TX_FIFO_DEPTH`, 8: TX FIFO entries. Power of two, ≥ 2.
- `clk_i`  in  1  system clock. One clock domain only.
- `rst_i`  in  1  synchronous, active-high reset.
- `S_DEVICE_strobe_i`  in  1  one-cycle request pulse. Address, rw, byte enable and data are valid only in this cycle.
- `S_DEVICE_addr_i`  in  ADDR_WIDTH  byte address. Only bits [3:2] are decoded.
- `S_DEVICE_rw_i`  in  1  1 = write, 0 = read.
- `S_DEVICE_byte_enable_i`  in  DATA_WIDTH/8  write byte lanes.
- `S_DEVICE_data_i`  in  DATA_WIDTH  write data.
- `S_DEVICE_data_ready_o`  out  1  one-cycle completion pulse.
- `S_DEVICE_data_o`  out  DATA_WIDTH  read data. Valid while `data_ready_o` = 1.
- `uart_tx_o`  out  1  serial output. Idles high.
- `uart_rx_i`  in  1  asynchronous serial input.

## Operation
- **Register map** (addr[3:2]):
  - **0 RXDATA (R):** returns {24'b0, rx_byte}. The read clears rx_valid. Writes are ignored.
  - **1 TXDATA (W):** if be[0] = 1 and the FIFO is not full, pushes data_i[7:0]. If the FIFO is full, the byte is dropped silently. Reads return 0.
  - **2 STATUS (R):** bit0 rx_valid, bit1 rx_overrun, bit2 tx_full, bit3 tx_empty, bit4 tx_busy, bit5 rx_frame_err. Other bits read 0.
  - **3 CTRL (W):** with be[0] = 1, writing data_i[1] = 1 clears rx_overrun and writing data_i[5] = 1 clears rx_frame_err. Reads return 0.
- **Bus response:** every strobe gets exactly one data_ready. This includes writes, unmapped lanes and dropped pushes. data_o is 0 for writes.
- **TX FIFO:** circular buffer with log2(TX_FIFO_DEPTH)+1-bit pointers; pointers wrap modulo depth.
  - Full: the pointers differ only in the MSB. Empty: the pointers are equal.
  - A push and a pop in the same cycle both take effect. A push is evaluated against the full flag at the start of the cycle, so a push into a full FIFO is dropped even if a pop happens that cycle.
- **TX state machine:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: if the FIFO is not empty, pop one byte into the shift register and go to START.
  - START: line 0. DATA: 8 bits, LSB first. STOP: line 1.
  - Each state lasts CLKS_PER_BIT cycles, timed by a bit counter.
  - tx_busy = (state ≠ IDLE).
  - On leaving STOP, if the FIFO is not empty, go directly to START with the next byte (back-to-back frames, no idle gap).
- **RX:**
  - uart_rx_i passes through a 2-flop synchronizer, reset value 1.
  - IDLE: on a falling edge go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is 1, treat it as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Stop bit 1: load rx_byte and set rx_valid. If rx_valid was already 1 and no RXDATA read occurs that cycle, set rx_overrun and the new byte overwrites the old one.
    - Stop bit 0: discard the byte and set rx_frame_err.
  - In every case return to IDLE.
- **Simultaneous byte completion and RXDATA read:** the read returns the old byte, the new byte loads, rx_valid stays 1 and there is no overrun.

## Timing
- **Reset** (synchronous, active for any cycle, including mid-frame):
  - Outputs: data_ready_o = 0, data_o = 0, uart_tx_o = 1.
  - State: both FSMs go to IDLE, the FIFO empties, rx_valid, rx_overrun and rx_frame_err clear, rx_byte = 0.
  - A frame interrupted by reset is abandoned. The line returns high in the cycle after reset is sampled.
- **Bus latency:** a strobe at cycle N gives data_ready_o = 1 at N+1 for exactly one cycle, with data_o registered.
  - Register side effects (push, rx_valid clear, flag clear) take effect at the clock edge ending cycle N.
  - STATUS read at N reflects state before cycle N's updates.
  - Back-to-back strobes on consecutive cycles are supported.
- **TX timing:** the first start bit appears on uart_tx_o 2 cycles after a push strobe into an empty, idle transmitter. One frame is 10 × CLKS_PER_BIT cycles.
- **RX timing:** rx_valid rises 1 cycle after the stop-bit sample point, which is ≈ 9.5 × CLKS_PER_BIT + 3 cycles after the falling start edge on uart_rx_i.

## Test plan
- **Reset:** hold rst_i for 3 cycles mid-TX-frame → uart_tx_o = 1 and STATUS reads 0x08 one cycle after release.
- **TX frame:** write TXDATA = 0x55 with be = 4'b0001, CLKS_PER_BIT = 8 → uart_tx_o shows 0,1,0,1,0,1,0,1,0,1, each bit 8 cycles wide. data_ready pulses exactly at N+1.
- **FIFO full:** 9 back-to-back writes 0x01..0x09 while TX is busy, depth 8 → STATUS bit2 = 1. The first 8 bytes are transmitted, 0x09 never appears, and all 9 strobes get data_ready.
- **RX byte:** drive 0xA3 at the bit rate → STATUS = 0x09. An RXDATA read returns 0x000000A3, and STATUS then reads 0x08.
- **Overrun:** receive 0x11 then 0x22 with no read → STATUS bit1 = 1 and RXDATA = 0x22. A CTRL write of 0x02 clears bit1.
- **Framing and glitch:**
  - Stop bit driven 0 → rx_frame_err = 1 and rx_valid stays 0.
  - A start pulse shorter than CLKS_PER_BIT/2 cycles → no byte and no flags.
